// File: rtl/core_pkg.sv
// ============================================================================
// core_pkg : shared width and fetch FSM state encoding for the core front end
// Revision : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        REQ       = 3'd0,
        WAIT_RESP = 3'd1,
        ISSUE     = 3'd2,
        WAIT_NEXT = 3'd3,
        FAULT     = 3'd4
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
// pc_fetch : architectural PC holder, single-outstanding instruction fetch.
//            Optional misaligned-next-PC trap under macro MISALIGN_TRAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_fetch
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc,
    input  logic            next_pc_valid,
    input  logic [XLEN-1:0] next_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] fetch_count,
    output logic            misalign_fault
);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] inst_pc_q;
    logic [XLEN-1:0] fetch_count_q;
    logic            misalign_q;

    logic [XLEN-1:0] pc_d;
    logic            next_pc_bad;

`ifdef MISALIGN_TRAP_EN
    assign pc_d        = next_pc;
    assign next_pc_bad = |next_pc[1:0];
`else
    // Without the trap, the low bits are simply dropped to keep fetches word aligned.
    logic unused_next_pc_lsbs;
    assign unused_next_pc_lsbs = ^next_pc[1:0];
    assign pc_d        = {next_pc[XLEN-1:2], 2'b00};
    assign next_pc_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            fetch_count_q <= '0;
            misalign_q    <= 1'b0;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_req_ready) begin
                        state_q <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (imem_resp_valid) begin
                        inst_q    <= imem_resp_data;
                        inst_pc_q <= pc_q;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (inst_ready) begin
                        fetch_count_q <= fetch_count_q + 32'd1;
                        state_q       <= WAIT_NEXT;
                    end
                end
                WAIT_NEXT: begin
                    if (next_pc_valid) begin
                        if (next_pc_bad) begin
                            misalign_q <= 1'b1;
                            state_q    <= FAULT;
                        end else begin
                            pc_q    <= pc_d;
                            state_q <= REQ;
                        end
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= REQ;
                end
            endcase
        end
    end

    // Valids are gated by rst_n so nothing is offered while reset is held.
    assign imem_req_valid = (state_q == REQ) && rst_n;
    assign inst_valid     = (state_q == ISSUE) && rst_n;
    assign imem_addr      = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_count    = fetch_count_q;

`ifdef MISALIGN_TRAP_EN
    assign misalign_fault = misalign_q;
`else
    logic unused_misalign_q;
    assign unused_misalign_q = misalign_q;
    assign misalign_fault    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
// tb_pc_fetch : scoreboard bench for pc_fetch (both MISALIGN_TRAP_EN builds)
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_fetch;
    import core_pkg::*;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        next_pc_valid;
    logic [31:0] next_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_count;
    logic        misalign_fault;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } sb_t;

    sb_t         sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    logic        exp_fault;

    pc_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc              (pc),
        .next_pc_valid   (next_pc_valid),
        .next_pc         (next_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .fetch_count     (fetch_count),
        .misalign_fault  (misalign_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // next_pc_valid is only legal while the FSM waits for it.
    always @(posedge clk) begin
        if (rst_n && next_pc_valid) begin
            checks++;
            if (dut.state_q !== WAIT_NEXT) begin
                errors++;
                $display("FAIL next_pc_valid_state: state=%0d required %0d", dut.state_q, WAIT_NEXT);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] data, input int req_stall, input int dec_stall,
                            input logic [31:0] npc, input bit preload);
        int          waitc;
        int          lat;
        sb_t         e;
        logic [31:0] held_inst;
        waitc = 0;
        while (imem_req_valid !== 1'b1 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        checks++;
        if (imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: imem_req_valid=%b required 1", imem_req_valid);
            return;
        end
        checks++;
        if (imem_addr !== exp_pc || pc !== exp_pc) begin
            errors++;
            $display("FAIL imem_addr: addr=%h pc=%h required %h", imem_addr, pc, exp_pc);
        end
        for (int i = 0; i < req_stall; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin
                errors++;
                $display("FAIL req_stall: valid=%b addr=%h required 1 %h", imem_req_valid, imem_addr, exp_pc);
            end
        end
        imem_req_ready = 1'b1;
        e.inst = data;
        e.pc   = exp_pc;
        sb_q.push_back(e);
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_resp_outputs: req_valid=%b inst_valid=%b required 0 0", imem_req_valid, inst_valid);
        end
        @(negedge clk);
        lat = 2;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        while (inst_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2 || inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency: cycles=%0d inst_valid=%b required 2 1", lat, inst_valid);
            return;
        end
        held_inst = inst;
        for (int i = 0; i < dec_stall; i++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst !== held_inst || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL dec_stall: inst_valid=%b inst=%h req_valid=%b required 1 %h 0",
                         inst_valid, inst, imem_req_valid, held_inst);
            end
        end
        if (preload) begin
            force dut.fetch_count_q = 32'hFFFF_FFFF;
            @(negedge clk);
            release dut.fetch_count_q;
            #1;
            exp_count = 32'hFFFF_FFFF;
            checks++;
            if (fetch_count !== exp_count) begin
                errors++;
                $display("FAIL preload: fetch_count=%h required %h", fetch_count, exp_count);
            end
        end
        inst_ready = 1'b1;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: entries=0 required 1");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (inst !== e.inst || inst_pc !== e.pc) begin
                errors++;
                $display("FAIL inst: inst=%h inst_pc=%h required %h %h", inst, inst_pc, e.inst, e.pc);
            end
        end
        exp_count = exp_count + 32'd1;
        @(negedge clk);
        inst_ready = 1'b0;
        checks++;
        if (fetch_count !== exp_count || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_count: count=%h inst_valid=%b required %h 0", fetch_count, inst_valid, exp_count);
        end
        next_pc_valid = 1'b1;
        next_pc       = npc;
        @(negedge clk);
        next_pc_valid = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (npc[1:0] != 2'b00) exp_fault = 1'b1;
        else                   exp_pc    = npc;
`else
        exp_pc = {npc[31:2], 2'b00};
`endif
        checks++;
        if (pc !== exp_pc || misalign_fault !== exp_fault || imem_req_valid !== !exp_fault) begin
            errors++;
            $display("FAIL next_pc: pc=%h fault=%b req_valid=%b required %h %b %b",
                     pc, misalign_fault, imem_req_valid, exp_pc, exp_fault, !exp_fault);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        exp_pc    = C_RESET_PC;
        exp_count = 32'h0;
        exp_fault = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        exp_pc    = C_RESET_PC;
        exp_count = 32'h0;
        exp_fault = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 32'h0 ||
            inst !== 32'h0 || inst_pc !== 32'h0 || misalign_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b iv=%b cnt=%h inst=%h ipc=%h mf=%b required all 0",
                     imem_req_valid, inst_valid, fetch_count, inst, inst_pc, misalign_fault);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (pc !== C_RESET_PC || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: pc=%h req_valid=%b required %h 1", pc, imem_req_valid, C_RESET_PC);
        end
    endtask

    task automatic test_basic();
        do_fetch(32'h0000_0013, 0, 0, 32'h0000_0004, 1'b0);
    endtask

    task automatic test_branch();
        do_fetch(32'h0040_0093, 0, 0, 32'h0000_0040, 1'b0);
        do_fetch(32'h00A0_0113, 0, 0, 32'h0000_0044, 1'b0);
    endtask

    task automatic test_stall();
        do_fetch(32'hDEAD_0033, 3, 5, 32'h0000_0048, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pc !== C_RESET_PC || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pc=%h req=%b iv=%b required %h 0 0", pc, imem_req_valid, inst_valid, C_RESET_PC);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        @(negedge clk);
        sb_q.delete();
        exp_pc    = C_RESET_PC;
        exp_count = 32'h0;
        checks++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || inst !== 32'h0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_drop: req=%b iv=%b inst=%h cnt=%h required 1 0 0 0",
                     imem_req_valid, inst_valid, inst, fetch_count);
        end
    endtask

    task automatic test_wrap();
        do_fetch(32'h0000_0073, 0, 2, 32'h0000_0100, 1'b1);
        checks++;
        if (fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL wrap: fetch_count=%h required 00000000", fetch_count);
        end
    endtask

    task automatic test_misalign();
        do_fetch(32'h1234_5678, 0, 0, 32'h0000_0102, 1'b0);
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || misalign_fault !== 1'b1 || pc !== 32'h0000_0100) begin
                errors++;
                $display("FAIL fault_hold: req=%b iv=%b mf=%b pc=%h required 0 0 1 00000100",
                         imem_req_valid, inst_valid, misalign_fault, pc);
            end
        end
        apply_reset();
        checks++;
        if (misalign_fault !== 1'b0 || imem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL fault_reset: mf=%b req=%b required 0 1", misalign_fault, imem_req_valid);
        end
`else
        checks++;
        if (imem_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL align: imem_addr=%h required 00000100", imem_addr);
        end
        do_fetch(32'h8765_4321, 0, 0, 32'h0000_0104, 1'b0);
`endif
    endtask

    initial begin
        rst_n           = 1'b0;
        next_pc_valid   = 1'b0;
        next_pc         = 32'h0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        inst_ready      = 1'b0;
        exp_pc          = C_RESET_PC;
        exp_count       = 32'h0;
        exp_fault       = 1'b0;
        test_reset();
        test_basic();
        test_branch();
        test_stall();
        test_reset_mid();
        test_wrap();
        test_misalign();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: entries=%0d required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time=%0t required finish earlier", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
